// File: rtl/timer_pkg.sv
// Shared state and mode encodings for the multi-channel tick timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_timer_ch.sv
// One timer channel: counts tick_in up to a latched terminal value and
// pulses timeout, either once (then DONE) or every period.
module tick_timer_ch #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_in,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] term,
  output logic             timeout,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count
);
  import timer_pkg::*;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_term_q;
  logic             r_mode_q;
  logic             r_timeout;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] w_last;

  // term_q = 0 wraps to all-ones, giving a full 2^CNT_W tick period.
  assign w_last = r_term_q - CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_term_q  <= '0;
      r_mode_q  <= MODE_ONESHOT;
      r_timeout <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      if (stop) begin
        r_state <= ST_IDLE;
        r_count <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else if (start) begin
        r_state  <= ST_RUN;
        r_count  <= '0;
        r_term_q <= term;
        r_mode_q <= mode;
        r_busy   <= 1'b1;
        r_done   <= 1'b0;
      end else if (tick_in && (r_state == ST_RUN)) begin
        if (r_count == w_last) begin
          r_count   <= '0;
          r_timeout <= 1'b1;
          if (r_mode_q == MODE_ONESHOT) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end else begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign timeout = r_timeout;
  assign busy    = r_busy;
  assign done    = r_done;
  assign count   = r_count;

endmodule

// File: rtl/multi_tick_timer.sv
// NUM_CH independent tick timers sharing clk, rst and tick_in; packs the
// per-channel scalar ports into flat vectors.
module multi_tick_timer #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned NUM_CH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick_in,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*CNT_W-1:0] term,
  output logic [NUM_CH-1:0]       timeout,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*CNT_W-1:0] count
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    tick_timer_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .tick_in(tick_in),
      .start  (start[g]),
      .stop   (stop[g]),
      .mode   (mode[g]),
      .term   (term[g*CNT_W +: CNT_W]),
      .timeout(timeout[g]),
      .busy   (busy[g]),
      .done   (done[g]),
      .count  (count[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_tick_timer.sv
// Scoreboard bench for multi_tick_timer: stimulus pushes hand-computed
// per-channel expectations, a negedge monitor pops and compares them.
module tb_multi_tick_timer;
  localparam int CW = 4;
  localparam int NC = 4;

  logic             clk;
  logic             rst;
  logic             tick_in;
  logic [NC-1:0]    start;
  logic [NC-1:0]    stop;
  logic [NC-1:0]    mode;
  logic [NC*CW-1:0] term;
  logic [NC-1:0]    timeout;
  logic [NC-1:0]    busy;
  logic [NC-1:0]    done;
  logic [NC*CW-1:0] count;

  multi_tick_timer #(.CNT_W(CW), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .start(start), .stop(stop),
    .mode(mode), .term(term), .timeout(timeout), .busy(busy), .done(done),
    .count(count)
  );

  typedef struct {
    int            at;
    int            ch;
    logic [CW+2:0] val;
    string         name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   stim_done = 0;

  logic [CW-1:0] pcnt [0:6] = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
  logic          pto  [0:6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp(input int ch, input logic t, input logic b, input logic d,
                     input logic [CW-1:0] c, input string nm);
    exp_t e;
    e.at = cyc + 1;
    e.ch = ch;
    e.val = {t, b, d, c};
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start   = '0;
    stop    = '0;
    tick_in = 1'b0;
  endtask

  task automatic set_term(input int ch, input logic [CW-1:0] v);
    term[ch*CW +: CW] = v;
  endtask

  task automatic ind(input logic s0, input logic s1, input logic tk,
                     input logic [CW-1:0] c0, input logic to0,
                     input logic [CW-1:0] c1, input logic to1,
                     input logic b1, input logic d1);
    start[0] = s0;
    start[1] = s1;
    tick_in  = tk;
    exp(0, to0, 1'b1, 1'b0, c0, "ind_ch0");
    exp(1, to1, b1, d1, c1, "ind_ch1");
    step();
  endtask

  // Monitor: compare every expectation due at this cycle, then wrap up.
  initial begin : monitor
    exp_t          e;
    logic [CW+2:0] got;
    int            drain = 0;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].at <= cyc) begin
        e = q.pop_front();
        got = {timeout[e.ch], busy[e.ch], done[e.ch], count[e.ch*CW +: CW]};
        n_vec++;
        if (e.at != cyc || got !== e.val) begin
          n_err++;
          $display("FAIL %s ch%0d cyc%0d: got {to,busy,done,cnt}=%b required %b",
                   e.name, e.ch, cyc, got, e.val);
        end
      end
      if (stim_done) begin
        drain++;
        if (q.size() > 0 && drain > 8) begin
          n_err += q.size();
          $display("FAIL drain: %0d expectations never checked", q.size());
          q.delete();
        end
        if (q.size() == 0) begin
          $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
          $finish;
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset held for two edges with start and tick active.
    rst = 1'b1; tick_in = 1'b1; start = '1; stop = '0; mode = '1; term = '1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NC; c++) exp(c, 1'b0, 1'b0, 1'b0, 4'd0, "reset");
      @(posedge clk); #1;
    end
    rst = 1'b0; start = '0; tick_in = 1'b0;
    for (int c = 0; c < NC; c++) exp(c, 1'b0, 1'b0, 1'b0, 4'd0, "post_reset");
    step();

    // One-shot, term = 3, ticks every 5 cycles.
    mode[0] = 1'b0; set_term(0, 4'd3); start[0] = 1'b1;
    exp(0, 1'b0, 1'b1, 1'b0, 4'd0, "os_start");
    step();
    for (int t = 1; t <= 5; t++) begin
      tick_in = 1'b1;
      if (t < 3)       exp(0, 1'b0, 1'b1, 1'b0, 4'(t), "os_tick");
      else if (t == 3) exp(0, 1'b1, 1'b0, 1'b1, 4'd0, "os_term");
      else             exp(0, 1'b0, 1'b0, 1'b1, 4'd0, "os_after");
      step();
      for (int g = 0; g < 4; g++) begin
        if (t < 3) exp(0, 1'b0, 1'b1, 1'b0, 4'(t), "os_hold");
        else       exp(0, 1'b0, 1'b0, 1'b1, 4'd0, "os_done");
        step();
      end
    end

    // Periodic, term = 2, 7 ticks; term/mode changed mid-run must not matter.
    mode[1] = 1'b1; set_term(1, 4'd2); start[1] = 1'b1;
    exp(1, 1'b0, 1'b1, 1'b0, 4'd0, "per_start");
    step();
    set_term(1, 4'd5); mode[1] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick_in = 1'b1;
      exp(1, pto[i], 1'b1, 1'b0, pcnt[i], "per_tick");
      step();
      exp(1, 1'b0, 1'b1, 1'b0, pcnt[i], "per_gap");
      step();
    end

    // term = 0 with 4-bit counter: timeout after the 16th tick.
    mode[2] = 1'b0; set_term(2, 4'd0); start[2] = 1'b1;
    exp(2, 1'b0, 1'b1, 1'b0, 4'd0, "t0_start");
    step();
    for (int i = 1; i <= 16; i++) begin
      tick_in = 1'b1;
      if (i < 16) exp(2, 1'b0, 1'b1, 1'b0, 4'(i), "t0_tick");
      else        exp(2, 1'b1, 1'b0, 1'b1, 4'd0, "t0_term");
      step();
    end
    tick_in = 1'b1;
    exp(2, 1'b0, 1'b0, 1'b1, 4'd0, "t0_done");
    step();

    // term = 1 periodic with tick held high; tick in the start cycle ignored.
    mode[3] = 1'b1; set_term(3, 4'd1); start[3] = 1'b1; tick_in = 1'b1;
    exp(3, 1'b0, 1'b1, 1'b0, 4'd0, "t1_start_tick");
    step();
    for (int i = 0; i < 5; i++) begin
      tick_in = 1'b1;
      exp(3, 1'b1, 1'b1, 1'b0, 4'd0, "t1_every");
      step();
    end

    // Start against a terminal tick, then stop against a terminal tick at count 2.
    mode[0] = 1'b0; set_term(0, 4'd3); start[0] = 1'b1;
    exp(0, 1'b0, 1'b1, 1'b0, 4'd0, "sim_start");
    step();
    tick_in = 1'b1; exp(0, 1'b0, 1'b1, 1'b0, 4'd1, "sim_c1"); step();
    tick_in = 1'b1; exp(0, 1'b0, 1'b1, 1'b0, 4'd2, "sim_c2"); step();
    start[0] = 1'b1; tick_in = 1'b1;
    exp(0, 1'b0, 1'b1, 1'b0, 4'd0, "start_vs_term");
    step();
    tick_in = 1'b1; exp(0, 1'b0, 1'b1, 1'b0, 4'd1, "sim_c1b"); step();
    tick_in = 1'b1; exp(0, 1'b0, 1'b1, 1'b0, 4'd2, "sim_c2b"); step();
    stop[0] = 1'b1; tick_in = 1'b1;
    exp(0, 1'b0, 1'b0, 1'b0, 4'd0, "stop_vs_term");
    step();
    exp(0, 1'b0, 1'b0, 1'b0, 4'd0, "stop_after");
    step();

    // Stop and start together on a running channel: stop wins.
    stop[1] = 1'b1; start[1] = 1'b1;
    exp(1, 1'b0, 1'b0, 1'b0, 4'd0, "stop_start");
    step();
    tick_in = 1'b1;
    exp(1, 1'b0, 1'b0, 1'b0, 4'd0, "idle_tick");
    step();

    // Independence: ch0 periodic term 3, ch1 one-shot term 5, both restarted.
    mode[0] = 1'b1; set_term(0, 4'd3);
    mode[1] = 1'b0; set_term(1, 4'd5);
    ind(1, 1, 0, 4'd0, 0, 4'd0, 0, 1, 0);
    ind(0, 0, 1, 4'd1, 0, 4'd1, 0, 1, 0);
    ind(0, 0, 1, 4'd2, 0, 4'd2, 0, 1, 0);
    ind(0, 0, 1, 4'd0, 1, 4'd3, 0, 1, 0);
    ind(0, 0, 1, 4'd1, 0, 4'd4, 0, 1, 0);
    ind(0, 1, 1, 4'd2, 0, 4'd0, 0, 1, 0);
    ind(0, 0, 1, 4'd0, 1, 4'd1, 0, 1, 0);
    ind(0, 0, 1, 4'd1, 0, 4'd2, 0, 1, 0);
    ind(0, 0, 1, 4'd2, 0, 4'd3, 0, 1, 0);
    ind(0, 0, 1, 4'd0, 1, 4'd4, 0, 1, 0);
    ind(0, 0, 1, 4'd1, 0, 4'd0, 1, 0, 1);
    ind(1, 0, 1, 4'd0, 0, 4'd0, 0, 0, 1);
    ind(0, 0, 1, 4'd1, 0, 4'd0, 0, 0, 1);

    stim_done = 1'b1;
  end

endmodule
